bin_to_xs3_seq: RTL

//  Sequential, parametrised binary-to-multi-digit excess-3 (or BCD) converter.

---
 rtl/bin_to_xs3_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bin_to_xs3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_xs3_seq
//  Purpose  : Sequential double-dabble converter from an unsigned binary
//             operand to DIGITS decimal digits, emitted as excess-3 (XS3=1)
//             or plain BCD (XS3=0). One input bit is consumed per clock.
//             An overflow flag marks operands above 10^DIGITS-1; in that case
//             dec_out carries the low DIGITS decimal digits.
//  Ports    : clk        rising-edge clock
//             rst_n      synchronous reset, active-low
//             in_valid   bin_in valid (accepted only while in_ready=1)
//             in_ready   converter idle and able to accept an operand
//             bin_in     unsigned binary operand, BIN_W bits
//             out_valid  dec_out/ovf valid, held until out_ready
//             out_ready  consumer accepts the result
//             dec_out    4*DIGITS bits, digit0 (units) in [3:0]
//             ovf        operand needed more than DIGITS digits
//  Revision : 1.0  initial release
// ============================================================================
module bin_to_xs3_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3,
    parameter int XS3    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dec_out,
    output logic                  ovf
);

    localparam int c_DW    = 4 * DIGITS;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [BIN_W-1:0]     bin_q,       bin_d;
    logic [c_DW-1:0]      dig_q,       dig_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    // Working overflow accumulates during CONV; the visible flag is only
    // refreshed in FIX so ovf stays stable alongside dec_out.
    logic                 ovf_acc_q,   ovf_acc_d;
    logic                 ovf_q,       ovf_d;
    logic [c_DW-1:0]      dec_q,       dec_d;
    logic                 out_valid_q, out_valid_d;

    logic [c_DW-1:0]      w_adj;   // digits after the >=5 -> +3 correction
    logic [c_DW-1:0]      w_code;  // final output coding of the digits

    // Per-digit arithmetic is 4-bit with no carry between digits.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign w_adj[gi*4 +: 4]  = (dig_q[gi*4 +: 4] >= 4'd5)
                                     ? dig_q[gi*4 +: 4] + 4'd3
                                     : dig_q[gi*4 +: 4];
            assign w_code[gi*4 +: 4] = (XS3 != 0)
                                     ? dig_q[gi*4 +: 4] + 4'd3
                                     : dig_q[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bin_q       <= '0;
            dig_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            ovf_q       <= 1'b0;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            dig_q       <= dig_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            ovf_q       <= ovf_d;
            dec_q       <= dec_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        dig_d       = dig_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        ovf_d       = ovf_q;
        dec_d       = dec_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d     = bin_in;
                    dig_d     = '0;
                    ovf_acc_d = 1'b0;
                    cnt_d     = c_CNT_INIT;
                    state_d   = S_CONV;
                end
            end
            S_CONV: begin
                // Shift {adjusted digits, operand} left by one; whatever
                // falls out of the top digit is a lost decimal carry.
                dig_d     = {w_adj[c_DW-2:0], bin_q[BIN_W-1]};
                bin_d     = bin_q << 1;
                ovf_acc_d = ovf_acc_q | w_adj[c_DW-1];
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_FIX: begin
                dec_d       = w_code;
                ovf_d       = ovf_acc_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign dec_out   = dec_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire
